// File: rtl/tick_pkg.sv
// Shared constants, interval state type and prescaler sizing for tick_gen.
// TICK_GEN_FAST_SIM_EN forces the base prescaler to divide by 2.
package tick_pkg;

    localparam int DEC_MOD = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ivl_state_t;

    function automatic int calc_pre_div(input int clk_hz, input int tick_hz);
`ifdef TICK_GEN_FAST_SIM_EN
        calc_pre_div = (clk_hz >= tick_hz) ? 2 : 2;
`else
        calc_pre_div = clk_hz / tick_hz;
`endif
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-MOD counter with advance/clear; wrap is the terminal event (combinational,
// high on the edge the counter rolls MOD-1 -> 0).
module tick_prescaler #(
    parameter int MOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic clear,
    output logic wrap
);

    localparam int             CW  = (MOD > 2) ? $clog2(MOD) : 1;
    localparam logic [CW-1:0]  MAX = CW'(MOD - 1);

    logic [CW-1:0] cnt;

    assign wrap = adv && !clear && (cnt == MAX);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (adv)
            cnt <= wrap ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/tick_gen.sv
// Game timebase: prescaled base tick, decade tick chain and an interval channel.
// Optional macro TICK_GEN_FAST_SIM_EN shortens the base tick to 2 cycles.
module tick_gen
    import tick_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int DECADES = 3,
    parameter int IVL_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    output logic [DECADES:0] tick,
    input  logic             ivl_load,
    input  logic [IVL_W-1:0] ivl_value,
    input  logic             ivl_periodic,
    input  logic             ivl_stop,
    output logic             ivl_busy,
    output logic             ivl_done
);

    localparam int PRE_DIV = calc_pre_div(CLK_HZ, TICK_HZ);

    if (PRE_DIV < 2) begin : g_bad_pre_div
        $error("tick_gen: PRE_DIV must be >= 2");
    end
`ifndef TICK_GEN_FAST_SIM_EN
    if ((CLK_HZ % TICK_HZ) != 0) begin : g_bad_ratio
        $error("tick_gen: CLK_HZ must be an integer multiple of TICK_HZ");
    end
`endif
    if (DECADES < 0 || DECADES > 6) begin : g_bad_decades
        $error("tick_gen: DECADES must be in 0..6");
    end

    // ev[k] is the tick[k] event on the current edge; tick is its registered copy.
    logic [DECADES:0] ev;

    tick_prescaler #(.MOD(PRE_DIV)) u_pre (
        .clk   (clk),
        .rst   (rst),
        .adv   (enable),
        .clear (clear),
        .wrap  (ev[0])
    );

    for (genvar k = 0; k < DECADES; k++) begin : g_dec
        tick_prescaler #(.MOD(DEC_MOD)) u_dec (
            .clk   (clk),
            .rst   (rst),
            .adv   (ev[k]),
            .clear (clear),
            .wrap  (ev[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst)
            tick <= '0;
        else
            tick <= ev;
    end

    ivl_state_t       state, state_n;
    logic [IVL_W-1:0] ivl_cnt, ivl_cnt_n;
    logic [IVL_W-1:0] ivl_rel, ivl_rel_n;
    logic             ivl_mode, ivl_mode_n;
    logic             done_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ivl_cnt  <= '0;
            ivl_rel  <= '0;
            ivl_mode <= 1'b0;
            ivl_done <= 1'b0;
        end else begin
            state    <= state_n;
            ivl_cnt  <= ivl_cnt_n;
            ivl_rel  <= ivl_rel_n;
            ivl_mode <= ivl_mode_n;
            ivl_done <= done_n;
        end
    end

    // A zero-length load is treated as no load, so expiry still proceeds.
    always_comb begin
        state_n    = state;
        ivl_cnt_n  = ivl_cnt;
        ivl_rel_n  = ivl_rel;
        ivl_mode_n = ivl_mode;
        done_n     = 1'b0;
        if (ivl_stop) begin
            state_n = IDLE;
        end else if (ivl_load && (ivl_value != '0)) begin
            state_n    = ARMED;
            ivl_cnt_n  = ivl_value;
            ivl_rel_n  = ivl_value;
            ivl_mode_n = ivl_periodic;
        end else if (state == ARMED && ev[0]) begin
            if (ivl_cnt == IVL_W'(1)) begin
                done_n = 1'b1;
                if (ivl_mode) begin
                    ivl_cnt_n = ivl_rel;
                end else begin
                    ivl_cnt_n = '0;
                    state_n   = IDLE;
                end
            end else begin
                ivl_cnt_n = ivl_cnt - IVL_W'(1);
            end
        end
    end

    assign ivl_busy = (state == ARMED);

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus random traffic against
// an arithmetic reference (phase count and absolute base-tick deadlines).
module tb_tick_gen;

    localparam int DEC = 2;
`ifdef TICK_GEN_FAST_SIM_EN
    localparam int PD = 2;
`else
    localparam int PD = 10;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           clear = 1'b0;
    logic           ivl_load = 1'b0;
    logic [15:0]    ivl_value = '0;
    logic           ivl_periodic = 1'b0;
    logic           ivl_stop = 1'b0;
    logic [DEC:0]   tick;
    logic           ivl_busy;
    logic           ivl_done;

    always #5 clk = ~clk;

    tick_gen #(.CLK_HZ(10), .TICK_HZ(1), .DECADES(DEC), .IVL_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .tick         (tick),
        .ivl_load     (ivl_load),
        .ivl_value    (ivl_value),
        .ivl_periodic (ivl_periodic),
        .ivl_stop     (ivl_stop),
        .ivl_busy     (ivl_busy),
        .ivl_done     (ivl_done)
    );

    int checks = 0, passed = 0, fails = 0, cyc = 0;
    // Reference: n = enabled cycles since last reset/clear; bt = base ticks since reset.
    int n = 0, bt = 0, target = 0, period = 0;
    bit armed = 1'b0, per = 1'b0;
    logic [DEC+2:0] expv = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit l,
                        input logic [15:0] v, input bit p, input bit s);
        bit ev, ed;
        logic [DEC:0] et;
        int pw;
        rst = r; enable = e; clear = c; ivl_load = l;
        ivl_value = v; ivl_periodic = p; ivl_stop = s;
        @(posedge clk);
        cyc++;
        et = '0;
        ed = 1'b0;
        if (!r) begin
            n = 0; bt = 0; armed = 1'b0; per = 1'b0; target = 0; period = 0;
        end else begin
            if (c) n = 0;
            else if (e) n++;
            ev = e && !c && (n % PD == 0);
            pw = PD;
            for (int k = 0; k <= DEC; k++) begin
                et[k] = ev && (n % pw == 0);
                pw = pw * 10;
            end
            if (ev) bt++;
            if (s) begin
                armed = 1'b0;
            end else if (l && v != 0) begin
                armed = 1'b1; per = p; period = int'(v); target = bt + int'(v);
            end else if (armed && ev && bt == target) begin
                ed = 1'b1;
                if (per) target = target + period;
                else armed = 1'b0;
            end
        end
        expv = {et, ed, armed};
        #1;
        check("tick_done_busy", {tick, ivl_done, ivl_busy}, expv);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int first;
        bit hit;

        // reset state
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
        check("reset_outputs", {tick, ivl_done, ivl_busy}, 0);

        // first base tick lands in cycle PD
        first = 0;
        for (int i = 1; i <= PD + 2; i++) begin
            step(1, 1, 0, 0, 0, 0, 0);
            if (tick[0] === 1'b1 && first == 0) first = i;
        end
        check("first_tick0_cycle", first, PD);
        run(PD * 100);

        // pause 7 cycles with pre_cnt = 4
        hit = 1'b0;
        for (int i = 0; i < 4 * PD && !hit; i++) begin
            if (n % PD == 4 % PD) hit = 1'b1;
            else step(1, 1, 0, 0, 0, 0, 0);
        end
        check("reach_pause_point", hit, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 0);
        run(3 * PD);

        // clear at pre_cnt = 6, dec_cnt[0] = 3
        hit = 1'b0;
        for (int i = 0; i < 200 * PD && !hit; i++) begin
            if (n % PD == 6 % PD && (n / PD) % 10 == 3) hit = 1'b1;
            else step(1, 1, 0, 0, 0, 0, 0);
        end
        check("reach_clear_point", hit, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        check("clear_no_tick", tick, 0);
        run(PD * 100 + 5);

        // one-shot of 3, then periodic of 2 until stopped
        step(1, 1, 0, 1, 3, 0, 0);
        check("oneshot_busy", ivl_busy, 1);
        run(4 * PD);
        check("oneshot_idle", ivl_busy, 0);
        step(1, 1, 0, 1, 2, 1, 0);
        run(10 * PD);
        step(1, 1, 0, 0, 0, 0, 1);
        check("stop_idle", ivl_busy, 0);
        run(3 * PD);

        // reload of 5 on the exact expiry edge suppresses done
        step(1, 1, 0, 1, 2, 1, 0);
        hit = 1'b0;
        for (int i = 0; i < 10 * PD && !hit; i++) begin
            if (armed && n % PD == PD - 1 && bt + 1 == target) hit = 1'b1;
            else step(1, 1, 0, 0, 0, 0, 0);
        end
        check("reach_expiry_edge", hit, 1);
        step(1, 1, 0, 1, 5, 0, 0);
        check("load_at_expiry_no_done", ivl_done, 0);
        run(6 * PD);

        // zero-length load is ignored
        step(1, 1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 1, 0, 1, 0);
        check("load_zero_busy", ivl_busy, 0);
        run(2);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step(1, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 29) == 0, 16'($urandom_range(0, 5)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);

        // reset mid-run with the channel armed
        step(1, 1, 0, 1, 1, 1, 0);
        run(PD - 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("midrun_reset_outputs", {tick, ivl_done, ivl_busy}, 0);
        run(2 * PD);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
